// File: rtl/ibuffer_parcel_sequencer_pkg.sv
// Shared widths and helpers for the instruction-buffer parcel sequencer.
package ibuffer_parcel_sequencer_pkg;

   localparam int unsigned PARCEL_W = 16;
   localparam int unsigned PC_W     = 32;
   localparam int unsigned INSTR_W  = 32;

   typedef logic [PARCEL_W-1:0] parcel_t;
   typedef logic [PC_W-1:0]     pc_t;

   // Byte address of parcel idx within a chunk whose parcel 0 sits at base.
   function automatic pc_t parcel_pc(input pc_t base, input int unsigned idx);
      return base + pc_t'(idx << 1);
   endfunction

endpackage

// File: rtl/ibuffer_marker.sv
// Finds the lowest remaining parcel of the head chunk and reports whether it
// starts an uncompressed (two-parcel) instruction.
module ibuffer_marker #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] remaining,
   input  logic [WIDTH-1:0] uncompressed,
   output logic             found,
   output logic [IDX_W-1:0] start,
   output logic             start_uncompressed
);

   always_comb begin
      found = |remaining;
      start = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (remaining[i]) start = IDX_W'(i);
      end
      start_uncompressed = found & uncompressed[start];
   end

endmodule

// File: rtl/ibuffer_parcel_sequencer.sv
// Two-entry chunk queue that slices fetched 16-bit parcels into compressed and
// uncompressed instructions, including ones straddling two chunks.
module ibuffer_parcel_sequencer
   import ibuffer_parcel_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                           CLK,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           enq_valid,
   output logic                           enq_ready,
   input  logic [WIDTH-1:0]               enq_valid_vec,
   input  logic [WIDTH-1:0]               enq_uncompressed_vec,
   input  logic [WIDTH-1:0][PARCEL_W-1:0] enq_parcels,
   input  logic [PC_W-1:0]                enq_pc,
   output logic                           deq_valid,
   input  logic                           deq_ready,
   output logic [INSTR_W-1:0]             deq_instr,
   output logic [PC_W-1:0]                deq_pc,
   output logic                           deq_is_compressed
);

   localparam int unsigned IDX_W = $clog2(WIDTH);

   typedef struct packed {
      parcel_t [WIDTH-1:0] parcels;
      logic [WIDTH-1:0]    valid;
      logic [WIDTH-1:0]    uncompressed;
      pc_t                 pc;
   } chunk_entry_t;

   chunk_entry_t     head_q, next_q, enq_chunk;
   logic [1:0]       count_q;
   logic [WIDTH-1:0] consumed_q;

   logic             head_live, enq_fire, deq_fire, pop;
   logic [WIDTH-1:0] remaining, take_mask, pop_consumed;
   logic             found, start_uncompressed, start_last;
   logic [IDX_W-1:0] start;

   assign enq_chunk = '{parcels: enq_parcels, valid: enq_valid_vec,
                        uncompressed: enq_uncompressed_vec, pc: enq_pc};
   assign enq_ready = (count_q < 2'd2) & ~flush;
   assign enq_fire  = enq_valid & enq_ready;
   assign head_live = count_q != 2'd0;
   assign remaining = head_live ? (head_q.valid & ~consumed_q) : '0;
   assign start_last = start == IDX_W'(WIDTH - 1);
   assign deq_fire  = deq_valid & deq_ready;

   ibuffer_marker #(.WIDTH(WIDTH)) u_marker (
      .remaining          (remaining),
      .uncompressed       (head_q.uncompressed),
      .found              (found),
      .start              (start),
      .start_uncompressed (start_uncompressed)
   );

   always_comb begin
      deq_valid         = 1'b0;
      deq_instr         = '0;
      deq_pc            = '0;
      deq_is_compressed = 1'b0;
      take_mask         = '0;
      pop               = 1'b0;
      pop_consumed      = '0;
      if (head_live) begin
         if (!found) begin
            pop = 1'b1;
         end else if (!start_uncompressed) begin
            deq_valid         = 1'b1;
            deq_instr         = {16'h0, head_q.parcels[start]};
            deq_pc            = parcel_pc(head_q.pc, 32'(start));
            deq_is_compressed = 1'b1;
            take_mask[start]  = 1'b1;
         end else if (!start_last) begin
            deq_valid                      = 1'b1;
            deq_instr                      = {head_q.parcels[start + IDX_W'(1)], head_q.parcels[start]};
            deq_pc                         = parcel_pc(head_q.pc, 32'(start));
            take_mask[start]               = 1'b1;
            take_mask[start + IDX_W'(1)]   = 1'b1;
         end else if (count_q == 2'd2) begin
            // Straddle: upper half lives in parcel 0 of the next chunk.
            if (next_q.valid[0]) begin
               deq_valid       = 1'b1;
               deq_instr       = {next_q.parcels[0], head_q.parcels[WIDTH-1]};
               deq_pc          = parcel_pc(head_q.pc, WIDTH - 1);
               pop_consumed[0] = 1'b1;
               pop             = deq_ready;
            end else begin
               pop = 1'b1;
            end
         end
      end
      if (deq_fire && ((remaining & ~take_mask) == '0)) pop = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (rst || flush) begin
         count_q    <= 2'd0;
         consumed_q <= '0;
      end else if (pop) begin
         consumed_q <= pop_consumed;
         if (count_q == 2'd2) begin
            head_q  <= next_q;
            count_q <= 2'd1;
         end else if (enq_fire) begin
            head_q <= enq_chunk;
         end else begin
            count_q <= 2'd0;
         end
      end else begin
         if (deq_fire) consumed_q <= consumed_q | take_mask;
         if (enq_fire) begin
            if (count_q == 2'd0) head_q <= enq_chunk;
            else                 next_q <= enq_chunk;
            count_q <= count_q + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_ibuffer_parcel_sequencer.sv
// Bench for ibuffer_parcel_sequencer: directed vector table, stall/reset
// sequence, and random traffic against a chunk-stream reference model.
module tb_ibuffer_parcel_sequencer;

   logic              CLK = 1'b0;
   logic              rst, flush, enq_valid, enq_ready, deq_valid, deq_ready;
   logic [7:0]        enq_valid_vec, enq_uncompressed_vec;
   logic [7:0][15:0]  enq_parcels;
   logic [31:0]       enq_pc, deq_instr, deq_pc;
   logic              deq_is_compressed;

   int checks = 0;
   int errors = 0;

   ibuffer_parcel_sequencer #(.WIDTH(8)) dut (
      .CLK(CLK), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_valid_vec(enq_valid_vec), .enq_uncompressed_vec(enq_uncompressed_vec),
      .enq_parcels(enq_parcels), .enq_pc(enq_pc),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_is_compressed(deq_is_compressed)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [7:0][15:0] p;
      logic [7:0]       v;
      logic [7:0]       u;
      logic [31:0]      pc;
   } tchunk_t;

   typedef struct {
      bit          enq;
      int          ci;
      bit          rdy;
      bit          fl;
      bit          ev;
      logic [31:0] ei;
      logic [31:0] ep;
      bit          ec;
      bit          er;
   } vec_t;

   tchunk_t    dch[5];
   vec_t       vecs[$];
   tchunk_t    mq[$];
   logic [7:0] mcons;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_chunk(input tchunk_t c);
      enq_parcels          = c.p;
      enq_valid_vec        = c.v;
      enq_uncompressed_vec = c.u;
      enq_pc               = c.pc;
   endtask

   task automatic add(input bit enq, input int ci, input bit rdy, input bit fl, input bit ev,
                      input logic [31:0] ei, input logic [31:0] ep, input bit ec, input bit er);
      vec_t r;
      r.enq = enq; r.ci = ci; r.rdy = rdy; r.fl = fl; r.ev = ev;
      r.ei = ei; r.ep = ep; r.ec = ec; r.er = er;
      vecs.push_back(r);
   endtask

   task automatic idle(input bit er);
      add(0, 0, 1, 0, 0, 0, 0, 0, er);
   endtask

   // Chunk-stream model: yields the next instruction the stream should produce.
   task automatic model_next(output bit ok, output logic [31:0] instr, output logic [31:0] pc,
                             output bit comp);
      int s;
      ok = 0; instr = '0; pc = '0; comp = 0;
      while (mq.size() != 0) begin
         s = -1;
         for (int i = 7; i >= 0; i--) if (mq[0].v[i] && !mcons[i]) s = i;
         if (s < 0) begin
            void'(mq.pop_front());
            mcons = '0;
            continue;
         end
         if (!mq[0].u[s]) begin
            ok = 1; comp = 1;
            instr = {16'h0, mq[0].p[s]};
            pc = mq[0].pc + 32'(2 * s);
            mcons[s] = 1'b1;
            return;
         end
         if (s < 7) begin
            ok = 1;
            instr = {mq[0].p[s+1], mq[0].p[s]};
            pc = mq[0].pc + 32'(2 * s);
            mcons[s] = 1'b1;
            mcons[s+1] = 1'b1;
            return;
         end
         if (mq.size() < 2) return;
         if (mq[1].v[0]) begin
            ok = 1;
            instr = {mq[1].p[0], mq[0].p[7]};
            pc = mq[0].pc + 32'd14;
            void'(mq.pop_front());
            mcons = 8'h01;
            return;
         end
         void'(mq.pop_front());
         mcons = '0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
      drive_chunk(dch[0]);
      repeat (2) @(posedge CLK);
      #1 rst = 1'b0;
   endtask

   initial begin
      tchunk_t cur;
      bit ok, ec;
      logic [31:0] ei, ep;
      int fires;

      for (int i = 0; i < 8; i++) begin
         dch[0].p[i] = 16'hA000 + 16'(i);
         dch[1].p[i] = 16'hB000 + 16'(i);
         dch[2].p[i] = 16'hC000 + 16'(i);
         dch[3].p[i] = 16'hD000 + 16'(i);
         dch[4].p[i] = 16'hE000 + 16'(i);
      end
      dch[0].v = 8'hFF; dch[0].u = 8'h00; dch[0].pc = 32'h1000;
      dch[1].v = 8'hFF; dch[1].u = 8'h55; dch[1].pc = 32'h1000;
      dch[2].v = 8'hFF; dch[2].u = 8'h80; dch[2].pc = 32'h2000;
      dch[3].v = 8'hFF; dch[3].u = 8'h00; dch[3].pc = 32'h2010;
      dch[4].v = 8'hFE; dch[4].u = 8'h00; dch[4].pc = 32'h2010;

      // All-compressed chunk
      add(1, 0, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++)
         add(0, 0, 1, 0, 1, {16'h0, 16'hA000 + 16'(i)}, 32'h1000 + 32'(2 * i), 1, 1);
      idle(1);
      // Alternating uncompressed starts
      add(1, 1, 1, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++)
         add(0, 0, 1, 0, 1, {16'hB001 + 16'(2 * k), 16'hB000 + 16'(2 * k)},
             32'h1000 + 32'(4 * k), 0, 1);
      idle(1);
      // Straddle waiting for a late next chunk
      add(1, 2, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++)
         add(0, 0, 1, 0, 1, {16'h0, 16'hC000 + 16'(i)}, 32'h2000 + 32'(2 * i), 1, 1);
      idle(1); idle(1);
      add(1, 3, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 1, {16'hD000, 16'hC007}, 32'h200E, 0, 0);
      for (int i = 1; i < 8; i++)
         add(0, 0, 1, 0, 1, {16'h0, 16'hD000 + 16'(i)}, 32'h2010 + 32'(2 * i), 1, 1);
      idle(1);
      // Straddle whose next chunk lacks parcel 0: dangling parcel dropped
      add(1, 2, 1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++)
         add(0, 0, 1, 0, 1, {16'h0, 16'hC000 + 16'(i)}, 32'h2000 + 32'(2 * i), 1, 1);
      add(1, 4, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < 8; i++)
         add(0, 0, 1, 0, 1, {16'h0, 16'hE000 + 16'(i)}, 32'h2010 + 32'(2 * i), 1, 1);
      idle(1);
      // Flush with two chunks queued, output pending and enqueue attempted
      add(1, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 1, 0, 0, 1, {16'h0, 16'hA000}, 32'h1000, 1, 1);
      add(1, 3, 1, 1, 1, {16'h0, 16'hA000}, 32'h1000, 1, 0);
      idle(1); idle(1);

      do_reset();
      @(negedge CLK);
      chk("reset_deq_valid", 32'(deq_valid), 32'd0);
      chk("reset_enq_ready", 32'(enq_ready), 32'd1);
      chk("reset_deq_instr", deq_instr, 32'd0);
      chk("reset_deq_pc", deq_pc, 32'd0);
      @(posedge CLK); #1;

      foreach (vecs[n]) begin
         flush = vecs[n].fl; enq_valid = vecs[n].enq; deq_ready = vecs[n].rdy;
         drive_chunk(dch[vecs[n].ci]);
         @(negedge CLK);
         chk($sformatf("vec%0d_valid", n), 32'(deq_valid), 32'(vecs[n].ev));
         chk($sformatf("vec%0d_enq_ready", n), 32'(enq_ready), 32'(vecs[n].er));
         if (vecs[n].ev) begin
            chk($sformatf("vec%0d_instr", n), deq_instr, vecs[n].ei);
            chk($sformatf("vec%0d_pc", n), deq_pc, vecs[n].ep);
            chk($sformatf("vec%0d_compressed", n), 32'(deq_is_compressed), 32'(vecs[n].ec));
         end
         @(posedge CLK); #1;
      end

      // Stall with valid output, then reset mid-stall
      flush = 0; enq_valid = 1; deq_ready = 0; drive_chunk(dch[1]);
      @(posedge CLK); #1;
      enq_valid = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("stall_valid", 32'(deq_valid), 32'd1);
         chk("stall_instr", deq_instr, {16'hB001, 16'hB000});
         chk("stall_pc", deq_pc, 32'h1000);
         @(posedge CLK); #1;
      end
      rst = 1;
      @(posedge CLK); #1;
      rst = 0;
      @(negedge CLK);
      chk("rst_stall_valid", 32'(deq_valid), 32'd0);
      chk("rst_stall_enq_ready", 32'(enq_ready), 32'd1);
      deq_ready = 1;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rst_stall_empty", 32'(deq_valid), 32'd0);
      @(posedge CLK); #1;

      // Random traffic
      mq.delete(); mcons = '0; fires = 0;
      for (int cyc = 0; cyc < 3040; cyc++) begin
         for (int i = 0; i < 8; i++) cur.p[i] = 16'($urandom);
         cur.v  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         cur.u  = 8'($urandom);
         cur.pc = $urandom & 32'hFFFF_FFF0;
         enq_valid = (cyc < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
         deq_ready = (cyc < 3000) ? ($urandom_range(0, 3) != 0) : 1'b1;
         drive_chunk(cur);
         @(negedge CLK);
         if (deq_valid && deq_ready) begin
            fires++;
            model_next(ok, ei, ep, ec);
            chk("rand_expected", 32'(ok), 32'd1);
            if (ok) begin
               chk("rand_instr", deq_instr, ei);
               chk("rand_pc", deq_pc, ep);
               chk("rand_compressed", 32'(deq_is_compressed), 32'(ec));
            end
         end
         if (enq_valid && enq_ready) mq.push_back(cur);
         @(posedge CLK); #1;
      end
      model_next(ok, ei, ep, ec);
      chk("drain_pending", 32'(ok), 32'd0);
      chk("rand_progress", 32'(fires > 500), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
